// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ready bus between the memory-stage controller (master)
// and the data memory (slave).
interface mem_stage_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 12
);
   logic                  dmem_req;
   logic                  dmem_we;
   logic [ADDR_WIDTH-1:0] dmem_addr;
   logic [31:0]           dmem_wdata;
   logic                  dmem_ready;
   logic [31:0]           dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: stalls the pipeline front while a load/store runs
// on the data-memory bus. Optional access timeout enabled by MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   input  logic                in_mem_read,
   input  logic                in_mem_write,
   input  logic [31:0]         in_ALU_result,
   input  logic [31:0]         in_data_reg,
   mem_stage_ctrl_if.master    dmem,
   output logic                stall,
   output logic                out_valid,
   output logic [31:0]         out_load_data,
   output logic                mem_error
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  we_q;

   logic mem_op;
   logic capture;
   logic load_en;
   logic timeout_hit;
   logic timeout_fire;
   logic req;

   // Only the low word-address bits reach memory.
   logic unused_addr_bits;
   assign unused_addr_bits = ^in_ALU_result[31:ADDR_WIDTH];

   assign mem_op = in_valid & (in_mem_read | in_mem_write);

   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      req          = 1'b0;
      stall        = 1'b0;
      out_valid    = 1'b0;
      capture      = 1'b0;
      load_en      = 1'b0;
      timeout_fire = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_op) begin
               stall   = 1'b1;
               capture = 1'b1;
               state_d = S_ACCESS;
            end else begin
               out_valid = in_valid;
            end
         end
         S_ACCESS: begin
            req   = 1'b1;
            stall = 1'b1;
            if (dmem.dmem_ready) begin
               load_en = ~we_q;
               state_d = S_DONE;
            end else if (timeout_hit) begin
               timeout_fire = 1'b1;
               state_d      = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (reset) begin
         stall     = 1'b0;
         out_valid = 1'b0;
      end
   end

   // Read/write precedence: a store wins when both flags are set.
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q        <= '0;
         wdata_q       <= '0;
         we_q          <= 1'b0;
         out_load_data <= '0;
      end else begin
         if (capture) begin
            addr_q  <= in_ALU_result[ADDR_WIDTH-1:0];
            wdata_q <= in_data_reg;
            we_q    <= in_mem_write;
         end
         if (load_en)           out_load_data <= dmem.dmem_rdata;
         else if (timeout_fire) out_load_data <= '0;
      end
   end

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;

`ifdef MEM_TIMEOUT_EN
   logic [31:0] wait_cnt_q;

   // Abort on the edge where the incremented count would reach TIMEOUT_CYCLES,
   // so exactly TIMEOUT_CYCLES ACCESS cycles elapse before DONE.
   assign timeout_hit = ((wait_cnt_q + 32'd1) >= TIMEOUT_CYCLES);

   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt_q <= '0;
         mem_error  <= 1'b0;
      end else begin
         if (capture)
            wait_cnt_q <= '0;
         else if (state_q == S_ACCESS && !dmem.dmem_ready)
            wait_cnt_q <= wait_cnt_q + 32'd1;
         mem_error <= timeout_fire;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout_hit        = 1'b0;
   assign mem_error          = 1'b0;
`endif

endmodule
